gray_count_decoder: RTL
=======================

Name: gray_count_decoder

Overview:
- Receive end of the team's Gray-coded counter interface: samples a WIDTH-bit Gray count and converts it back to binary.
- Tracks successive values and reports each legal ±1 step as a one-cycle pulse.
- Detects and counts illegal multi-step jumps.
- Sits on the consumer side of any Gray counter output, typically across a clock boundary.

Parameters:
- WIDTH, 4, bit width of Gray input and binary output (WIDTH >= 2)
- SYNC_STAGES, 2, number of synchronizer flops when GRAY_SYNC_EN is defined (>= 2)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  tracking enable
- err_clr  input  1  clears err_sticky and err_count
- g_in  input  WIDTH  Gray-coded count from the encoder side
- b_out  output  WIDTH  decoded binary value, registered
- b_valid  output  1  b_out holds a tracked value
- step_up  output  1  one-cycle pulse: new value = previous + 1 mod 2^WIDTH
- step_down  output  1  one-cycle pulse: new value = previous - 1 mod 2^WIDTH
- err  output  1  one-cycle pulse: illegal jump detected
- err_sticky  output  1  latched error flag
- err_count  output  8  saturating illegal-jump count

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - Every register clears asynchronously: input/sync flops, b_out, b_valid, step_up, step_down, err, err_sticky, err_count.
  - FSM goes to INIT.
  - Reset mid-operation, including in FAULT, has the same effect; no pulse is generated on release.
- Input stage: g_in is registered into g_s. Depth S = 1 flop without GRAY_SYNC_EN, S = SYNC_STAGES with it.
- Decode (combinational on g_s): bin[WIDTH-1] = g_s[WIDTH-1]; bin[i] = bin[i+1] XOR g_s[i] for i = WIDTH-2 down to 0.
- diff = bin - b_out, computed modulo 2^WIDTH.
- Latency: a change on g_in appears on b_out, together with its step/err pulse, S+1 rising edges later.
- FSM states: INIT, TRACK, FAULT. All outputs are registered.
  - en=0, any state: next state INIT, b_valid<=0, no pulses. b_out holds its value; the input stage keeps sampling.
  - INIT with en=1: b_out<=bin, b_valid<=1, no pulses, next state TRACK.
  - TRACK/FAULT with en=1, diff=0: b_out holds, no pulses, state unchanged.
  - TRACK/FAULT with en=1, diff=1: b_out<=bin, step_up<=1, state unchanged.
  - TRACK/FAULT with en=1, diff=all-ones (-1): b_out<=bin, step_down<=1, state unchanged.
  - TRACK/FAULT with en=1, any other diff: b_out<=bin (resync), err<=1, err_sticky<=1, err_count increments, next state FAULT.
- Wrap-around is legal:
  - 2^WIDTH-1 -> 0 is step_up.
  - 0 -> 2^WIDTH-1 is step_down.
- Pulses: step_up, step_down and err are mutually exclusive and last exactly one cycle per event.
- FAULT: tracking continues normally, err_sticky stays high.
- err_clr:
  - Alone: next edge clears err_sticky and err_count; FAULT -> TRACK.
  - With a simultaneous error: the error wins. err_count becomes 1, err_sticky stays 1, state stays FAULT.
  - In INIT or TRACK: clears the counter and flag only.
- err_count saturates at 255 and does not wrap.

Optional Feature:
- Macro: GRAY_SYNC_EN.
- Defined: g_in passes through a SYNC_STAGES-deep flop chain. Use when g_in comes from another clock domain; the Gray property guarantees at most one uncertain bit per sample. Latency = SYNC_STAGES+1 edges.
- Undefined: single capture register (S=1). Use for same-clock sources. Latency = 2 edges.
- Decode, FSM and error logic are identical in both builds.

Test Plan (WIDTH=4, GRAY_SYNC_EN undefined unless noted):
- Reset release, en=1, g_in stepped one code per clk through 0000,0001,0011,0010,0110 -> b_out goes 0,1,2,3,4, each lagging 2 edges. b_valid=1 from first sample; step_up pulses on 4 consecutive cycles; err stays 0.
- Wrap: g_in 1000 (bin 15) then 0000 -> b_out=0, single step_up pulse. Then g_in back to 1000 -> b_out=15, single step_down pulse.
- Illegal jump from tracked 0000 to 0011 (bin 2) -> err pulse, err_sticky=1, err_count=1, b_out=2, state FAULT. Then g_in=0010 (bin 3) -> step_up, err_sticky still 1.
- Start in FAULT with err_count=1; assert err_clr in the same cycle as a new jump 0010->0101 (bin 3->6) -> err=1, err_count=1, err_sticky=1. Then err_clr alone -> err_count=0, err_sticky=0.
- Drop en for 3 cycles, change g_in to 0110 (bin 4), raise en -> b_valid=0 while en=0. First sample with en=1 gives b_out=4, b_valid=1, no step/err pulse.
- Reset asserted mid-clock while in FAULT with err_count=5 -> all outputs 0 immediately. GRAY_SYNC_EN defined with SYNC_STAGES=3: a single g_in change appears on b_out after 4 edges.

Source files
------------

// File: rtl/gray_count_decoder.sv
// gray_count_decoder: receive end of a Gray-coded counter link.
// Samples g_in, converts it to binary, and tracks successive values.
// A +1 step gives a step_up pulse and a -1 step gives a step_down pulse.
// Any other jump gives an err pulse. It also sets err_sticky and bumps the
// saturating err_count.
//
// Optional macro GRAY_SYNC_EN: g_in passes through a SYNC_STAGES-deep
// synchronizer chain instead of a single capture flop.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   en         tracking enable
//   err_clr    clears err_sticky / err_count
//   g_in       Gray-coded count from the encoder side
//   b_out      decoded binary value (registered)
//   b_valid    b_out holds a tracked value
//   step_up    one-cycle pulse, value advanced by +1
//   step_down  one-cycle pulse, value moved by -1
//   err        one-cycle pulse, illegal jump
//   err_sticky latched error flag
//   err_count  saturating illegal-jump count
module gray_count_decoder #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] g_in,
    output logic [WIDTH-1:0] b_out,
    output logic             b_valid,
    output logic             step_up,
    output logic             step_down,
    output logic             err,
    output logic             err_sticky,
    output logic [7:0]       err_count
);

`ifdef GRAY_SYNC_EN
    localparam int unsigned STAGES = SYNC_STAGES;
`else
    localparam int unsigned STAGES = 1;
`endif

    localparam logic [WIDTH-1:0] DIFF_UP   = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIFF_DOWN = '1;
    localparam logic [7:0]       CNT_MAX   = 8'hFF;

    // Reject parameter values the structure cannot support.
    if (WIDTH < 2 || SYNC_STAGES < 2) begin : g_param_check
        $error("gray_count_decoder: WIDTH and SYNC_STAGES must both be >= 2");
    end

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                       state, state_nxt;
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             g_s;
    logic [WIDTH-1:0]             bin;
    logic [WIDTH-1:0]             diff;

    logic [WIDTH-1:0] b_out_nxt;
    logic             b_valid_nxt;
    logic             step_up_nxt;
    logic             step_down_nxt;
    logic             err_nxt;
    logic             err_sticky_nxt;
    logic [7:0]       err_count_nxt;

    // Input capture / synchronizer chain; the last stage feeds the decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= g_in;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_s = sync_q[STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        logic acc;
        acc = 1'b0;
        bin = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            acc    = acc ^ g_s[i];
            bin[i] = acc;
        end
    end

    assign diff = bin - b_out;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_nxt      = state;
        b_out_nxt      = b_out;
        b_valid_nxt    = b_valid;
        step_up_nxt    = 1'b0;
        step_down_nxt  = 1'b0;
        err_nxt        = 1'b0;
        err_sticky_nxt = err_sticky;
        err_count_nxt  = err_count;

        // A clear lands first so that a same-cycle error overrides it.
        if (err_clr) begin
            err_sticky_nxt = 1'b0;
            err_count_nxt  = 8'd0;
            if (state == ST_FAULT) begin
                state_nxt = ST_TRACK;
            end
        end

        if (!en) begin
            state_nxt   = ST_INIT;
            b_valid_nxt = 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    b_out_nxt   = bin;
                    b_valid_nxt = 1'b1;
                    state_nxt   = ST_TRACK;
                end
                ST_TRACK, ST_FAULT: begin
                    b_valid_nxt = 1'b1;
                    if (diff == '0) begin
                        b_out_nxt = b_out;
                    end else if (diff == DIFF_UP) begin
                        b_out_nxt   = bin;
                        step_up_nxt = 1'b1;
                    end else if (diff == DIFF_DOWN) begin
                        b_out_nxt     = bin;
                        step_down_nxt = 1'b1;
                    end else begin
                        // Illegal jump: resync to the new value and flag it.
                        b_out_nxt      = bin;
                        err_nxt        = 1'b1;
                        err_sticky_nxt = 1'b1;
                        if (err_count_nxt != CNT_MAX) begin
                            err_count_nxt = err_count_nxt + 8'd1;
                        end
                        state_nxt = ST_FAULT;
                    end
                end
                default: begin
                    state_nxt   = ST_INIT;
                    b_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_out      <= '0;
            b_valid    <= 1'b0;
            step_up    <= 1'b0;
            step_down  <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            b_out      <= b_out_nxt;
            b_valid    <= b_valid_nxt;
            step_up    <= step_up_nxt;
            step_down  <= step_down_nxt;
            err        <= err_nxt;
            err_sticky <= err_sticky_nxt;
            err_count  <= err_count_nxt;
        end
    end

endmodule
